bus_addr_dec: RTL and testbench
===============================

# bus_addr_dec

Parametrised, registered address decoder for the shared system bus. It sits between the bus arbiter's granted master and NUM_SLV slaves. It drives a one-hot combinational slave select for the current transfer and a one-cycle-delayed read-data select that matches single-cycle-latency slaves. Transfers that hit no slave region produce a decode-error pulse and are logged in an error counter and a last-error capture register.

## Interface
- ADDR_W, 16, address width.
- NUM_SLV, 4, number of slave regions (1..8).
- SLV_BASE, {16'hF000,16'h8000,16'h7000,16'h0000}, packed NUM_SLV*ADDR_W region base addresses; slot i is slave i.
- SLV_LAST, {16'hF0FF,16'h8FFF,16'h71FF,16'h07FF}, packed NUM_SLV*ADDR_W inclusive region end addresses.
- CNT_W, 8, error counter width.

Ports:
- clk  in  1  bus clock, rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- m_grant  in  1  current master holds the bus.
- m_req  in  1  master issues a transfer this cycle.
- m_wr  in  1  1 = write, 0 = read.
- address  in  ADDR_W  transfer address.
- err_clr  in  1  synchronous clear of the error log.
- s_sel  out  NUM_SLV  one-hot slave select, combinational.
- rd_sel  out  NUM_SLV  registered read-data mux select.
- dec_err  out  1  registered one-cycle decode-error pulse.
- err_cnt  out  CNT_W  saturating count of decode errors.
- err_addr  out  ADDR_W  address of the most recent decode error.
- err_wr  out  1  m_wr of the most recent decode error.

## Operation
- Valid transfer: v = m_grant & m_req.
- Region hit: hit[i] = SLV_BASE[i] <= address <= SLV_LAST[i]. Comparisons are unsigned and full ADDR_W.
- Overlapping regions: the lowest index wins. s_sel is the priority-encoded one-hot of hit, gated by v.
- When v=0, s_sel is 0 regardless of address. This covers no grant, and grant without a request.
- A region with SLV_BASE > SLV_LAST never hits.
- rd_sel is registered on each clk edge:
  - Loads s_sel when v & ~m_wr.
  - Otherwise loads 0.
  - As a result, rd_sel is never held past one cycle.
- Decode error: miss = v & ~|hit. On each clk edge, dec_err <= miss.
- On a miss:
  - err_cnt increments, saturating at 2^CNT_W-1.
  - err_addr <= address.
  - err_wr <= m_wr.
- err_clr: err_cnt <= 0. err_addr and err_wr are held.
- err_clr and a miss in the same cycle: the miss wins. err_cnt <= 1 and the capture registers update.
- Writes to unmapped space are not forwarded: s_sel = 0.

## Timing
- s_sel: zero latency, combinational from m_grant, m_req and address.
- rd_sel and dec_err: valid exactly one cycle after the address phase, and high for exactly one cycle per transfer.
- Back-to-back transfers are supported every cycle, with no bubbles.
- Reset (reset_n low, asynchronous, including mid-transfer):
  - rd_sel, dec_err, err_cnt, err_addr and err_wr go to 0 immediately.
  - s_sel keeps following its inputs.
  - A transfer in flight during reset is dropped: no rd_sel and no dec_err after release.

## Configuration
- BUS_ADDR_ERR_LOG_EN defined: err_cnt, err_addr and err_wr registers are built as described above.
- BUS_ADDR_ERR_LOG_EN undefined:
  - err_cnt, err_addr and err_wr are tied to 0.
  - err_clr is ignored.
  - dec_err, s_sel and rd_sel behave identically to the defined case.

## Structure
- Shared package bus_addr_pkg holds:
  - default map constants SLV0..SLV3 BASE/LAST;
  - default ADDR_W, NUM_SLV and CNT_W;
  - the counter saturation value expression.
- Sub-module bus_addr_region: a single-region inclusive range comparator (base, last, address -> hit).
  - Instantiated NUM_SLV times in a generate loop.
  - The priority encoder and registers stay in bus_addr_dec.

## Test plan
- Read, v=1, m_wr=0, address 16'h0400 -> s_sel=4'b0001 the same cycle; rd_sel=4'b0001 the next cycle, then 0.
- Write to 16'h7100 then read 16'h8000 in consecutive cycles:
  - s_sel = 0010, then 0100;
  - rd_sel = 0000 after the write, then 0100 one cycle after the read.
- m_grant=0, m_req=1, address 16'h0000 -> s_sel=0, no rd_sel, no dec_err, err_cnt unchanged.
- Unmapped write to 16'h0800:
  - s_sel=0;
  - the next cycle: dec_err=1, err_cnt=1, err_addr=16'h0800, err_wr=1.
- 300 consecutive misses -> err_cnt holds at 255.
- Miss with err_clr asserted in the same cycle -> err_cnt=1.
- err_clr alone -> err_cnt=0 and err_addr is kept.
- reset_n pulsed low mid-read of 16'h0010 -> rd_sel, dec_err and err_cnt are 0 asynchronously, and no rd_sel appears after release.
- Overlap case, SLV_BASE1 = 16'h0000 and address 16'h0100 -> s_sel=0001.

Source files
------------

// File: rtl/bus_addr_pkg.sv
// Shared constants for the system-bus address decoder: default slave map,
// default widths and the error-counter saturation value.
package bus_addr_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned NUM_SLV_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 8;

    localparam logic [15:0] SLV0_BASE = 16'h0000;
    localparam logic [15:0] SLV0_LAST = 16'h07FF;
    localparam logic [15:0] SLV1_BASE = 16'h7000;
    localparam logic [15:0] SLV1_LAST = 16'h71FF;
    localparam logic [15:0] SLV2_BASE = 16'h8000;
    localparam logic [15:0] SLV2_LAST = 16'h8FFF;
    localparam logic [15:0] SLV3_BASE = 16'hF000;
    localparam logic [15:0] SLV3_LAST = 16'hF0FF;

    // Slot i of the packed vectors is slave i.
    localparam logic [63:0] DEF_SLV_BASE = {SLV3_BASE, SLV2_BASE, SLV1_BASE, SLV0_BASE};
    localparam logic [63:0] DEF_SLV_LAST = {SLV3_LAST, SLV2_LAST, SLV1_LAST, SLV0_LAST};

    function automatic logic [63:0] sat_val(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/bus_addr_region.sv
// Single-region inclusive range comparator; a region with base > last never hits.
module bus_addr_region
    import bus_addr_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] last,
    input  logic [ADDR_W-1:0] address,
    output logic              hit
);

    assign hit = (address >= base) && (address <= last);

endmodule

// File: rtl/bus_addr_dec.sv
// Registered system-bus address decoder with one-hot slave select, read-data
// select and decode-error logging (logging built only with BUS_ADDR_ERR_LOG_EN).
module bus_addr_dec
    import bus_addr_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_SLV = NUM_SLV_DEF,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_LAST = DEF_SLV_LAST,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               m_grant,
    input  logic               m_req,
    input  logic               m_wr,
    input  logic [ADDR_W-1:0]  address,
    input  logic               err_clr,
    output logic [NUM_SLV-1:0] s_sel,
    output logic [NUM_SLV-1:0] rd_sel,
    output logic               dec_err,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [ADDR_W-1:0]  err_addr,
    output logic               err_wr
);

    logic [NUM_SLV-1:0] hit;
    logic [NUM_SLV-1:0] pri_sel;
    logic               found;
    logic               v;
    logic               miss;

    for (genvar i = 0; i < NUM_SLV; i++) begin : g_region
        bus_addr_region #(.ADDR_W(ADDR_W)) u_region (
            .base    (SLV_BASE[i*ADDR_W +: ADDR_W]),
            .last    (SLV_LAST[i*ADDR_W +: ADDR_W]),
            .address (address),
            .hit     (hit[i])
        );
    end

    // Overlapping regions resolve to the lowest slave index.
    always_comb begin
        pri_sel = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (hit[i] && !found) begin
                pri_sel[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign v     = m_grant & m_req;
    assign miss  = v & ~|hit;
    assign s_sel = v ? pri_sel : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel  <= '0;
            dec_err <= 1'b0;
        end else begin
            rd_sel  <= (v && !m_wr) ? pri_sel : '0;
            dec_err <= miss;
        end
    end

`ifdef BUS_ADDR_ERR_LOG_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_val(CNT_W));

    // A miss in the same cycle as err_clr restarts the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt  <= '0;
            err_addr <= '0;
            err_wr   <= 1'b0;
        end else if (miss) begin
            if (err_clr)
                err_cnt <= CNT_W'(1);
            else if (err_cnt != CNT_MAX)
                err_cnt <= err_cnt + CNT_W'(1);
            err_addr <= address;
            err_wr   <= m_wr;
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;
    assign err_cnt  = '0;
    assign err_addr = '0;
    assign err_wr   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_addr_dec.sv
// Self-checking bench for bus_addr_dec: directed scenarios plus randomized
// traffic against an address-map reference model.
module tb_bus_addr_dec;

`ifdef BUS_ADDR_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_grant, m_req, m_wr, err_clr;
    logic [15:0] address;
    logic [3:0]  s_sel, rd_sel, o_s_sel, o_rd_sel;
    logic        dec_err, err_wr, o_dec_err, o_err_wr;
    logic [7:0]  err_cnt, o_err_cnt;
    logic [15:0] err_addr, o_err_addr;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [15:0] base_a [4] = '{16'h0000, 16'h7000, 16'h8000, 16'hF000};
    logic [15:0] last_a [4] = '{16'h07FF, 16'h71FF, 16'h8FFF, 16'hF0FF};

    // Expected state of the registered outputs.
    logic [3:0]  e_rd;
    logic        e_err, e_wr;
    int unsigned e_cnt;
    logic [15:0] e_addr;

    always #5 clk = ~clk;

    bus_addr_dec dut (
        .clk(clk), .reset_n(reset_n), .m_grant(m_grant), .m_req(m_req), .m_wr(m_wr),
        .address(address), .err_clr(err_clr), .s_sel(s_sel), .rd_sel(rd_sel),
        .dec_err(dec_err), .err_cnt(err_cnt), .err_addr(err_addr), .err_wr(err_wr)
    );

    bus_addr_dec #(
        .ADDR_W(16), .NUM_SLV(4),
        .SLV_BASE({16'hF000, 16'h8000, 16'h0000, 16'h0000}),
        .SLV_LAST({16'hF0FF, 16'h8FFF, 16'h71FF, 16'h07FF}),
        .CNT_W(8)
    ) dut_ovl (
        .clk(clk), .reset_n(reset_n), .m_grant(m_grant), .m_req(m_req), .m_wr(m_wr),
        .address(address), .err_clr(err_clr), .s_sel(o_s_sel), .rd_sel(o_rd_sel),
        .dec_err(o_dec_err), .err_cnt(o_err_cnt), .err_addr(o_err_addr), .err_wr(o_err_wr)
    );

    function automatic logic [3:0] ref_sel(input logic g, input logic r, input logic [15:0] a);
        if (!(g && r)) return 4'b0000;
        for (int i = 0; i < 4; i++)
            if (a >= base_a[i] && a <= last_a[i]) return 4'(1 << i);
        return 4'b0000;
    endfunction

    task automatic model_edge();
        logic [3:0] sel;
        logic       v, miss;
        v    = m_grant && m_req;
        sel  = ref_sel(m_grant, m_req, address);
        miss = v && (sel == 4'b0000);
        e_rd  = (v && !m_wr) ? sel : 4'b0000;
        e_err = miss;
        if (LOG_EN) begin
            if (miss) begin
                e_cnt  = err_clr ? 1 : ((e_cnt + 1 > 255) ? 255 : e_cnt + 1);
                e_addr = address;
                e_wr   = m_wr;
            end else if (err_clr) begin
                e_cnt = 0;
            end
        end
    endtask

    task automatic drive(input logic g, input logic r, input logic w,
                         input logic [15:0] a, input logic c);
        m_grant = g; m_req = r; m_wr = w; address = a; err_clr = c;
        #1;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0400, 1'b0);
        e_rd = '0; e_err = 1'b0; e_cnt = 0; e_addr = '0; e_wr = 1'b0;
        n_chk++; if (rd_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_rd_sel got %b exp 0000", rd_sel); end
        n_chk++; if (dec_err !== 1'b0) begin n_fail++; $display("FAIL reset_dec_err got %b exp 0", dec_err); end
        n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        n_chk++; if (err_addr !== 16'h0000 || err_wr !== 1'b0) begin n_fail++; $display("FAIL reset_capture got %h/%b exp 0000/0", err_addr, err_wr); end
        n_chk++; if (s_sel !== 4'b0001) begin n_fail++; $display("FAIL reset_s_sel_follows got %b exp 0001", s_sel); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read();
        drive(1'b1, 1'b1, 1'b0, 16'h0400, 1'b0);
        n_chk++; if (s_sel !== 4'b0001) begin n_fail++; $display("FAIL read_s_sel got %b exp 0001", s_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        n_chk++; if (rd_sel !== 4'b0001) begin n_fail++; $display("FAIL read_rd_sel got %b exp 0001", rd_sel); end
        tick();
        n_chk++; if (rd_sel !== 4'b0000) begin n_fail++; $display("FAIL read_rd_sel_drop got %b exp 0000", rd_sel); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b1, 16'h7100, 1'b0);
        n_chk++; if (s_sel !== 4'b0010) begin n_fail++; $display("FAIL b2b_wr_s_sel got %b exp 0010", s_sel); end
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h8000, 1'b0);
        n_chk++; if (rd_sel !== 4'b0000) begin n_fail++; $display("FAIL b2b_wr_rd_sel got %b exp 0000", rd_sel); end
        n_chk++; if (s_sel !== 4'b0100) begin n_fail++; $display("FAIL b2b_rd_s_sel got %b exp 0100", s_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        n_chk++; if (rd_sel !== 4'b0100) begin n_fail++; $display("FAIL b2b_rd_rd_sel got %b exp 0100", rd_sel); end
        tick();
    endtask

    task automatic test_no_grant();
        int unsigned cnt_before;
        cnt_before = e_cnt;
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        n_chk++; if (s_sel !== 4'b0000) begin n_fail++; $display("FAIL nogrant_s_sel got %b exp 0000", s_sel); end
        tick();
        n_chk++; if (rd_sel !== 4'b0000 || dec_err !== 1'b0) begin n_fail++; $display("FAIL nogrant_regs got %b/%b exp 0000/0", rd_sel, dec_err); end
        n_chk++; if (err_cnt !== 8'(cnt_before)) begin n_fail++; $display("FAIL nogrant_err_cnt got %0d exp %0d", err_cnt, cnt_before); end
    endtask

    task automatic test_unmapped_write();
        drive(1'b1, 1'b1, 1'b1, 16'h0800, 1'b0);
        n_chk++; if (s_sel !== 4'b0000) begin n_fail++; $display("FAIL unmapped_s_sel got %b exp 0000", s_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        n_chk++; if (dec_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_dec_err got %b exp 1", dec_err); end
        n_chk++; if (err_cnt !== (LOG_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL unmapped_err_cnt got %0d exp %0d", err_cnt, LOG_EN ? 1 : 0); end
        n_chk++; if (err_addr !== (LOG_EN ? 16'h0800 : 16'h0000) || err_wr !== LOG_EN) begin n_fail++; $display("FAIL unmapped_capture got %h/%b exp %h/%b", err_addr, err_wr, LOG_EN ? 16'h0800 : 16'h0000, LOG_EN); end
        tick();
        n_chk++; if (dec_err !== 1'b0) begin n_fail++; $display("FAIL unmapped_dec_err_drop got %b exp 0", dec_err); end
    endtask

    task automatic test_saturate();
        int unsigned bad = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(16'h0800, 16'h6FFF)), 1'b0);
            tick();
            if (dec_err !== 1'b1) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL sat_dec_err got %0d missing pulses exp 0", bad); end
        n_chk++; if (err_cnt !== (LOG_EN ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL sat_err_cnt got %0d exp %0d", err_cnt, LOG_EN ? 255 : 0); end
    endtask

    task automatic test_clr();
        drive(1'b1, 1'b1, 1'b0, 16'h9000, 1'b1);
        tick();
        n_chk++; if (err_cnt !== (LOG_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL clr_miss_err_cnt got %0d exp %0d", err_cnt, LOG_EN ? 1 : 0); end
        n_chk++; if (err_addr !== (LOG_EN ? 16'h9000 : 16'h0000)) begin n_fail++; $display("FAIL clr_miss_err_addr got %h exp %h", err_addr, LOG_EN ? 16'h9000 : 16'h0000); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        tick();
        n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_alone_err_cnt got %0d exp 0", err_cnt); end
        n_chk++; if (err_addr !== (LOG_EN ? 16'h9000 : 16'h0000)) begin n_fail++; $display("FAIL clr_alone_err_addr got %h exp %h", err_addr, LOG_EN ? 16'h9000 : 16'h0000); end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 16'hA000, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        e_rd = '0; e_err = 1'b0; e_cnt = 0; e_addr = '0; e_wr = 1'b0;
        n_chk++; if (rd_sel !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rd_sel got %b exp 0000", rd_sel); end
        n_chk++; if (dec_err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_err got %b/%0d exp 0/0", dec_err, err_cnt); end
        n_chk++; if (s_sel !== 4'b0001) begin n_fail++; $display("FAIL rstmid_s_sel got %b exp 0001", s_sel); end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        reset_n = 1'b1;
        tick();
        n_chk++; if (rd_sel !== 4'b0000 || dec_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got %b/%b exp 0000/0", rd_sel, dec_err); end
    endtask

    task automatic test_overlap();
        drive(1'b1, 1'b1, 1'b0, 16'h0100, 1'b0);
        n_chk++; if (o_s_sel !== 4'b0001) begin n_fail++; $display("FAIL overlap_low got %b exp 0001", o_s_sel); end
        drive(1'b1, 1'b1, 1'b0, 16'h7100, 1'b0);
        n_chk++; if (o_s_sel !== 4'b0010) begin n_fail++; $display("FAIL overlap_high got %b exp 0010", o_s_sel); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        n_chk++; if (o_rd_sel !== 4'b0010) begin n_fail++; $display("FAIL overlap_rd_sel got %b exp 0010", o_rd_sel); end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [3:0]  exp_sel;
        int unsigned k;
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0: a = base_a[k];
                1: a = last_a[k];
                2: a = base_a[k] - 16'd1;
                3: a = last_a[k] + 16'd1;
                default: a = 16'($urandom);
            endcase
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 15) == 0));
            exp_sel = ref_sel(m_grant, m_req, address);
            n_chk++; if (s_sel !== exp_sel) begin n_fail++; $display("FAIL rand_s_sel addr %h got %b exp %b", a, s_sel, exp_sel); end
            tick();
            n_chk++; if (rd_sel !== e_rd) begin n_fail++; $display("FAIL rand_rd_sel addr %h got %b exp %b", a, rd_sel, e_rd); end
            n_chk++; if (dec_err !== e_err) begin n_fail++; $display("FAIL rand_dec_err addr %h got %b exp %b", a, dec_err, e_err); end
            n_chk++; if (err_cnt !== 8'(e_cnt) || err_addr !== e_addr || err_wr !== e_wr) begin
                n_fail++; $display("FAIL rand_log got %0d/%h/%b exp %0d/%h/%b", err_cnt, err_addr, err_wr, e_cnt, e_addr, e_wr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_no_grant();
        test_unmapped_write();
        test_saturate();
        test_clr();
        test_reset_mid();
        test_overlap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
